// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word-in / bit-out bundle between an upstream producer and bit_serializer.
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic w;
  logic w_valid;
  logic last;
  logic busy;
  modport master (output din, din_valid, input din_ready, w, w_valid, last, busy);
  modport slave (input din, din_valid, output din_ready, w, w_valid, last, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial shifter with valid/ready input and optional idle gap.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP = 0
) (
  input logic clk,
  input logic rst,
  bit_serializer_if.slave bus
);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] FIN = CW'(NBITS - 1);
  localparam logic [CW-1:0] PRE = CW'(NBITS - 2);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic [3:0] gcnt;
  logic w, w_valid, last, fin, hs, nbit;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic par;
  assign nbit = cnt == CW'(WIDTH - 1) ? par : sreg[WIDTH-1];
`else
  assign nbit = sreg[WIDTH-1];
`endif
  // cnt indexes the bit currently on w, so fin marks the word's final cycle
  assign fin = state == SHIFT && cnt == FIN;
  assign bus.din_ready = state == IDLE || (GAP == 0 && fin);
  assign hs = bus.din_valid && bus.din_ready;
  assign bus.busy = state != IDLE;
  assign bus.w = w;
  assign bus.w_valid = w_valid;
  assign bus.last = last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      gcnt <= '0;
      w <= 1'b0;
      w_valid <= 1'b0;
      last <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par <= 1'b0;
`endif
    end else if (hs) begin
      state <= SHIFT;
      sreg <= bus.din << 1;
      cnt <= '0;
      w <= bus.din[WIDTH-1];
      w_valid <= 1'b1;
      last <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par <= ^bus.din;
`endif
    end else if (state == SHIFT && !fin) begin
      sreg <= sreg << 1;
      cnt <= cnt + 1'b1;
      w <= nbit;
      last <= cnt == PRE;
    end else if (state == SHIFT) begin
      state <= GAP > 0 ? GAP_WAIT : IDLE;
      gcnt <= '0;
      w <= 1'b0;
      w_valid <= 1'b0;
      last <= 1'b0;
    end else if (state == GAP_WAIT) begin
      state <= gcnt == 4'(GAP - 1) ? IDLE : GAP_WAIT;
      gcnt <= gcnt + 1'b1;
    end
  end
endmodule
